// File: rtl/cl_proto_pkg.sv
// Camera Link serial command protocol: FSM states, framing bytes, bank indices.
// Latency: n/a (declarations and a pure checksum/decode helper only).
// Backpressure: n/a.
package cl_proto_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CMD  = 3'd1,
        ST_GET_ADDR = 3'd2,
        ST_GET_DATA = 3'd3,
        ST_GET_CHK  = 3'd4,
        ST_COMMIT   = 3'd5,
        ST_RESP     = 3'd6
    } cl_state_e;

    localparam logic [7:0] CL_SOF    = 8'h55;
    localparam logic [7:0] CL_ACK    = 8'h06;
    localparam logic [7:0] CL_NAK    = 8'h15;
    localparam logic [3:0] CL_CMD_WR = 4'hA;

    localparam logic [1:0] CL_BANK_RB1 = 2'd0;
    localparam logic [1:0] CL_BANK_RB2 = 2'd1;
    localparam logic [1:0] CL_BANK_RB3 = 2'd2;
    localparam logic [1:0] CL_BANK_RB4 = 2'd3;

    // Frame checksum: XOR of the three payload bytes.
    function automatic logic [7:0] cl_chk(input logic [7:0] cmd,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

    // Bank field to one-hot write strobe vector {rb4, rb3, rb2, rb1}.
    function automatic logic [3:0] cl_bank_onehot(input logic [1:0] bank);
        logic [3:0] oh;
        oh = 4'b0000;
        case (bank)
            CL_BANK_RB1: oh = 4'b0001;
            CL_BANK_RB2: oh = 4'b0010;
            CL_BANK_RB3: oh = 4'b0100;
            CL_BANK_RB4: oh = 4'b1000;
            default:     oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/cl_gap_timer.sv
// Inter-byte gap timer: flags a stalled frame after TIMEOUT_CYC idle cycles.
// Latency: o_expired is combinational from the count register (same cycle).
// Backpressure: none; counts while i_run, clears on any byte or outside a frame.
module cl_gap_timer
#(
    parameter int unsigned TIMEOUT_CYC = 400000
)
(
    input  logic clk_fix,
    input  logic rst_fix_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(TIMEOUT_CYC));
    // A byte arriving in the expiry cycle wins: the frame is still alive.
    assign o_expired  = i_run && !i_clear && w_at_limit;

    // Count idle cycles inside a frame; hold at the limit so it cannot wrap.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_cnt <= '0;
        end else if (i_clear || !i_run) begin
            r_cnt <= '0;
        end else if (!w_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cl_serial_cmd_parser.sv
// Parses 5-byte CL serial write frames (SOF CMD ADDR DATA CHK) into one-cycle rbN_wen strobes plus ACK/NAK.
// Latency: wen + reg_addr/reg_data one cycle after CHK byte; response byte one cycle after that (NAK: one cycle after CHK).
// Backpressure: response held until tx_ready; rx bytes during COMMIT/RESP dropped. CL_TIMEOUT_EN adds the inter-byte gap abort.
module cl_serial_cmd_parser
    import cl_proto_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE    = CL_SOF,
    parameter logic [7:0]  ACK_BYTE    = CL_ACK,
    parameter logic [7:0]  NAK_BYTE    = CL_NAK,
    parameter int unsigned TIMEOUT_CYC = 400000
)
(
    input  logic       clk_fix,
    input  logic       rst_fix_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_byte,
    output logic       rb1_wen,
    output logic       rb2_wen,
    output logic       rb3_wen,
    output logic       rb4_wen,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic [7:0] frame_err_cnt
);

    cl_state_e  r_state;
    cl_state_e  w_state_nxt;

    logic [7:0] r_cmd;
    logic [7:0] r_addr;
    logic [7:0] r_data;
    logic [7:0] r_reg_addr;
    logic [7:0] r_reg_data;
    logic [3:0] r_wen;
    logic       r_tx_valid;
    logic [7:0] r_tx_byte;
    logic [7:0] r_err_cnt;

    logic       w_timeout;
    logic       w_take;
    logic       w_frame_ok;
    logic       w_accept;
    logic       w_reject;
    logic       w_tx_done;

`ifdef CL_TIMEOUT_EN
    logic       w_in_frame;

    assign w_in_frame = (r_state == ST_GET_CMD)  || (r_state == ST_GET_ADDR) ||
                        (r_state == ST_GET_DATA) || (r_state == ST_GET_CHK);

    cl_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk_fix   (clk_fix),
        .rst_fix_n (rst_fix_n),
        .i_clear   (rx_valid),
        .i_run     (w_in_frame),
        .o_expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // The command nibble is judged only with the checksum so a bad frame is always fully consumed.
    assign w_take     = rx_valid && !w_timeout;
    assign w_frame_ok = (rx_byte == cl_chk(r_cmd, r_addr, r_data)) && (r_cmd[7:4] == CL_CMD_WR);
    assign w_accept   = (r_state == ST_GET_CHK) && w_take && w_frame_ok;
    assign w_reject   = (r_state == ST_GET_CHK) && w_take && !w_frame_ok;
    assign w_tx_done  = r_tx_valid && tx_ready;

    // State register.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: bytes advance the frame; a SOF value inside the frame is plain payload.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == SOF_BYTE)) w_state_nxt = ST_GET_CMD;
            end
            ST_GET_CMD: begin
                if (w_timeout)   w_state_nxt = ST_IDLE;
                else if (w_take) w_state_nxt = ST_GET_ADDR;
            end
            ST_GET_ADDR: begin
                if (w_timeout)   w_state_nxt = ST_IDLE;
                else if (w_take) w_state_nxt = ST_GET_DATA;
            end
            ST_GET_DATA: begin
                if (w_timeout)   w_state_nxt = ST_IDLE;
                else if (w_take) w_state_nxt = ST_GET_CHK;
            end
            ST_GET_CHK: begin
                if (w_timeout)     w_state_nxt = ST_IDLE;
                else if (w_accept) w_state_nxt = ST_COMMIT;
                else if (w_reject) w_state_nxt = ST_RESP;
            end
            ST_COMMIT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (w_tx_done) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the payload bytes as they arrive.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_cmd  <= 8'h00;
            r_addr <= 8'h00;
            r_data <= 8'h00;
        end else if (w_take) begin
            if (r_state == ST_GET_CMD)  r_cmd  <= rx_byte;
            if (r_state == ST_GET_ADDR) r_addr <= rx_byte;
            if (r_state == ST_GET_DATA) r_data <= rx_byte;
        end
    end

    // Commit: address/data move to the register bus and one strobe fires, all in the COMMIT cycle.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_reg_addr <= 8'h00;
            r_reg_data <= 8'h00;
            r_wen      <= 4'b0000;
        end else begin
            r_wen <= w_accept ? cl_bank_onehot(r_cmd[1:0]) : 4'b0000;
            if (w_accept) begin
                r_reg_addr <= r_addr;
                r_reg_data <= r_data;
            end
        end
    end

    // Response driver: byte is loaded once and held until the transmitter takes it.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_tx_valid <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else if (r_state == ST_COMMIT) begin
            r_tx_valid <= 1'b1;
            r_tx_byte  <= ACK_BYTE;
        end else if (w_reject) begin
            r_tx_valid <= 1'b1;
            r_tx_byte  <= NAK_BYTE;
        end else if (w_tx_done) begin
            r_tx_valid <= 1'b0;
        end
    end

    // Rejected and timed-out frames are counted, saturating at 8'hFF.
    always_ff @(posedge clk_fix or negedge rst_fix_n) begin
        if (!rst_fix_n) begin
            r_err_cnt <= 8'h00;
        end else if ((w_reject || w_timeout) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign tx_valid      = r_tx_valid;
    assign tx_byte       = r_tx_byte;
    assign rb1_wen       = r_wen[0];
    assign rb2_wen       = r_wen[1];
    assign rb3_wen       = r_wen[2];
    assign rb4_wen       = r_wen[3];
    assign reg_addr      = r_reg_addr;
    assign reg_data      = r_reg_data;
    assign frame_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_cl_serial_cmd_parser.sv
// Self-checking bench for cl_serial_cmd_parser: directed frames plus randomized frames vs a frame-level model.
// Latency: expects wen one cycle after the CHK byte and the response held until tx_ready.
// Backpressure: tx_ready is withheld for random stretches; stray bytes are injected while a response is pending.
module tb_cl_serial_cmd_parser;

    localparam int TMO = 64;

    typedef logic [7:0] frame_t [5];

    typedef struct {
        int         bank;
        logic [7:0] addr;
        logic [7:0] data;
        int         c;
    } wr_t;

    logic       clk_fix   = 1'b0;
    logic       rst_fix_n = 1'b0;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_byte   = 8'h00;
    logic       tx_ready  = 1'b0;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       rb1_wen, rb2_wen, rb3_wen, rb4_wen;
    logic [7:0] reg_addr, reg_data, frame_err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int multi_wen = 0;

    // Reference model state: what a correct parser must have remembered.
    int         m_err  = 0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_data = 8'h00;

    wr_t wq[$];

    cl_serial_cmd_parser #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_fix       (clk_fix),
        .rst_fix_n     (rst_fix_n),
        .rx_valid      (rx_valid),
        .rx_byte       (rx_byte),
        .tx_ready      (tx_ready),
        .tx_valid      (tx_valid),
        .tx_byte       (tx_byte),
        .rb1_wen       (rb1_wen),
        .rb2_wen       (rb2_wen),
        .rb3_wen       (rb3_wen),
        .rb4_wen       (rb4_wen),
        .reg_addr      (reg_addr),
        .reg_data      (reg_data),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk_fix = ~clk_fix;

    always @(posedge clk_fix) cyc <= cyc + 1;

    // Strobe monitor: every cycle with a write strobe is recorded for the frame checker.
    always @(negedge clk_fix) begin
        logic [3:0] w;
        wr_t e;
        w = {rb4_wen, rb3_wen, rb2_wen, rb1_wen};
        if (w != 4'b0000) begin
            if ($countones(w) != 1) multi_wen++;
            e.bank = 0;
            for (int i = 0; i < 4; i++) if (w[i]) e.bank = i;
            e.addr = reg_addr;
            e.data = reg_data;
            e.c    = cyc;
            wq.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int c);
        @(negedge clk_fix);
        rx_valid = 1'b1;
        rx_byte  = b;
        c        = cyc;
        @(negedge clk_fix);
        rx_valid = 1'b0;
    endtask

    function automatic frame_t mk_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                        input logic [7:0] data, input logic [7:0] chk_flip);
        frame_t f;
        f[0] = 8'h55;
        f[1] = cmd;
        f[2] = addr;
        f[3] = data;
        f[4] = (cmd ^ addr ^ data) ^ chk_flip;
        return f;
    endfunction

    // Sends one frame, services the response and compares everything against the model.
    task automatic run_frame(input frame_t f, input int gmax, input int hold, input bit noise);
        bit         ok;
        int         q0, c, c_chk, w;
        logic [7:0] held;
        wr_t        e;
        ok = (f[4] == (f[1] ^ f[2] ^ f[3])) && (f[1][7:4] == 4'hA);
        q0 = wq.size();
        c_chk = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(f[i], c);
            if (i == 4) c_chk = c;
            else repeat ($urandom_range(0, gmax)) @(negedge clk_fix);
        end
        w = 0;
        while (!tx_valid && w < 20) begin
            @(negedge clk_fix);
            w++;
        end
        check("resp_arrives", tx_valid, 1'b1);
        check("resp_byte", tx_byte, ok ? 8'h06 : 8'h15);
        held = tx_byte;
        for (int i = 0; i < hold; i++) begin
            if (noise && i == 0) begin
                rx_valid = 1'b1;
                rx_byte  = 8'($urandom);
            end
            @(negedge clk_fix);
            rx_valid = 1'b0;
            check("resp_hold_vld", tx_valid, 1'b1);
            check("resp_hold_byte", tx_byte, held);
        end
        tx_ready = 1'b1;
        @(negedge clk_fix);
        tx_ready = 1'b0;
        check("resp_release", tx_valid, 1'b0);

        if (ok) begin
            m_addr = f[2];
            m_data = f[3];
        end else if (m_err < 255) begin
            m_err++;
        end
        check("wen_count", wq.size() - q0, ok ? 1 : 0);
        if (ok && wq.size() == q0 + 1) begin
            e = wq.pop_back();
            check("wen_bank", e.bank, f[1][1:0]);
            check("wen_addr", e.addr, f[2]);
            check("wen_data", e.data, f[3]);
            check("wen_latency", e.c, c_chk + 1);
        end
        wq.delete();
        check("reg_addr", reg_addr, m_addr);
        check("reg_data", reg_data, m_data);
        check("err_cnt", frame_err_cnt, m_err);
    endtask

    initial begin
        int         c, w;
        logic [7:0] cmd, b;

        // Reset state.
        repeat (3) @(negedge clk_fix);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_wen", {rb4_wen, rb3_wen, rb2_wen, rb1_wen}, 4'b0000);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_data", reg_data, 8'h00);
        check("rst_err", frame_err_cnt, 8'h00);
        rst_fix_n = 1'b1;
        repeat (2) @(negedge clk_fix);

        // Good write to bank 1, response held 5 cycles.
        run_frame(mk_frame(8'hA0, 8'h1A, 8'h3C, 8'h00), 0, 5, 1'b0);

        // Bank select 2..4.
        for (int k = 1; k < 4; k++) begin
            cmd = 8'hA0 | 8'(k);
            run_frame(mk_frame(cmd, 8'h04, 8'hFF, 8'h00), 1, 1, 1'b0);
        end

        // Bad checksum, then bad command nibble (checksum correct).
        run_frame(mk_frame(8'hA0, 8'h1A, 8'h3C, 8'hBA), 0, 2, 1'b0);
        run_frame(mk_frame(8'hB0, 8'h01, 8'h02, 8'h00), 0, 0, 1'b0);

        // Line noise before a frame is discarded silently.
        send_byte(8'h00, c);
        send_byte(8'hFF, c);
        send_byte(8'h12, c);
        run_frame(mk_frame(8'hA2, 8'h55, 8'h55, 8'h00), 0, 0, 1'b0);

        // Randomized frames, gaps, backpressure and stray bytes during the response.
        for (int n = 0; n < 200; n++) begin
            int         kind;
            logic [7:0] flip;
            kind = $urandom_range(0, 3);
            cmd  = {4'hA, 2'($urandom), 2'($urandom)};
            flip = 8'h00;
            if (kind == 2) flip = 8'($urandom_range(1, 255));
            if (kind == 3) begin
                cmd[7:4] = 4'($urandom);
                if (cmd[7:4] == 4'hA) cmd[7:4] = 4'h5;
            end
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                b = 8'($urandom);
                if (b == 8'h55) b = 8'h56;
                send_byte(b, c);
            end
            run_frame(mk_frame(cmd, 8'($urandom), 8'($urandom), flip),
                      3, $urandom_range(0, 4), 1'($urandom));
        end

`ifdef CL_TIMEOUT_EN
        // Stalled frame is abandoned silently and counted.
        begin
            int seen;
            seen = 0;
            send_byte(8'h55, c);
            send_byte(8'hA0, c);
            for (int i = 0; i < TMO + 6; i++) begin
                @(negedge clk_fix);
                if (tx_valid) seen++;
            end
            if (m_err < 255) m_err++;
            check("tmo_no_resp", seen, 0);
            check("tmo_err", frame_err_cnt, m_err);
            check("tmo_no_wen", wq.size(), 0);
            run_frame(mk_frame(8'hA3, 8'h77, 8'h88, 8'h00), 0, 0, 1'b0);
        end
`endif

        // Saturation of the error counter.
        tx_ready = 1'b0;
        for (int n = 0; n < 300; n++) begin
            run_frame(mk_frame(8'hA1, 8'($urandom), 8'($urandom), 8'h01), 0, 0, 1'b0);
        end
        check("err_saturated", frame_err_cnt, 8'hFF);

        // Reset while a response is pending drops it immediately.
        for (int i = 0; i < 5; i++) begin
            frame_t f;
            f = mk_frame(8'hA1, 8'h42, 8'h24, 8'h00);
            send_byte(f[i], c);
        end
        w = 0;
        while (!tx_valid && w < 10) begin
            @(negedge clk_fix);
            w++;
        end
        check("rstresp_pending", tx_valid, 1'b1);
        #2;
        rst_fix_n = 1'b0;
        #1;
        check("rstresp_tx_valid", tx_valid, 1'b0);
        check("rstresp_err", frame_err_cnt, 8'h00);
        check("rstresp_reg_addr", reg_addr, 8'h00);
        m_err  = 0;
        m_addr = 8'h00;
        m_data = 8'h00;
        @(negedge clk_fix);
        rst_fix_n = 1'b1;
        wq.delete();
        repeat (2) @(negedge clk_fix);
        run_frame(mk_frame(8'hA0, 8'h5A, 8'hC3, 8'h00), 1, 1, 1'b0);

        check("wen_onehot", multi_wen, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
